// File: rtl/led_scan_if.sv
// Panel-side and buffer-side signals of the LED scan scheduler.
// The scheduler is the master; the frame buffer/panel/USB side sees the slave view.
interface led_scan_if;
  logic        enable;
  logic        swap_request;
  logic        swap_ack;
  logic        front_buffer_sel;
  logic        rd_en;
  logic [3:0]  rd_row_addr;
  logic [3:0]  rd_bit_addr;
  logic        serial_clk;
  logic        latch_enable;
  logic        output_enable_n;
  logic [15:0] row_select_n;
  logic        frame_start;

  modport master (
    input  enable, swap_request,
    output swap_ack, front_buffer_sel, rd_en, rd_row_addr, rd_bit_addr,
           serial_clk, latch_enable, output_enable_n, row_select_n, frame_start
  );

  modport slave (
    output enable, swap_request,
    input  swap_ack, front_buffer_sel, rd_en, rd_row_addr, rd_bit_addr,
           serial_clk, latch_enable, output_enable_n, row_select_n, frame_start
  );
endinterface

// File: rtl/led_scan_scheduler.sv
// Row scan sequencer for the LED panel: shift a row out of the frame buffer,
// blank, latch, display, and swap front/back buffers at frame boundaries.
module led_scan_scheduler #(
  parameter int NUM_ROWS       = 16,
  parameter int BITS_PER_ROW   = 16,
  parameter int CLK_DIV        = 2,
  parameter int BLANK_CYCLES   = 8,
  parameter int DISPLAY_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  led_scan_if.master bus
);

  localparam int PHASES  = 2 * CLK_DIV;
  localparam int MAX_A   = (PHASES > BLANK_CYCLES) ? PHASES : BLANK_CYCLES;
  localparam int MAX_CNT = (MAX_A > DISPLAY_CYCLES) ? MAX_A : DISPLAY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] PHASE_LAST   = CNT_W'(PHASES - 1);
  localparam logic [CNT_W-1:0] HALF         = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISPLAY_LAST = CNT_W'(DISPLAY_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT     = 4'(BITS_PER_ROW - 1);
  localparam logic [3:0]       LAST_ROW     = 4'(NUM_ROWS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [3:0]         row_q, row_d;
  logic               fsel_q, fsel_d;
  logic               swap_ack_q, swap_ack_d;
  logic               rd_en_q, rd_en_d;
  logic [3:0]         rd_bit_q, rd_bit_d;
  logic               sclk_q, sclk_d;
  logic               latch_q, latch_d;
  logic               oe_n_q, oe_n_d;
  logic [15:0]        rs_q, rs_d;
  logic               frame_start_q, frame_start_d;
  logic               start_row;

  // Outputs are computed for the state being entered so every pin comes straight off a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    bit_d         = bit_q;
    row_d         = row_q;
    fsel_d        = fsel_q;
    rd_bit_d      = rd_bit_q;
    sclk_d        = sclk_q;
    oe_n_d        = oe_n_q;
    rs_d          = rs_q;
    rd_en_d       = 1'b0;
    latch_d       = 1'b0;
    swap_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    start_row     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        row_d  = '0;
        oe_n_d = 1'b1;
        rs_d   = '1;
        sclk_d = 1'b0;
        if (bus.enable) begin
          start_row     = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            state_d = BLANK;
            oe_n_d  = 1'b1;
            rs_d    = '1;
          end else begin
            bit_d    = bit_q + 4'd1;
            rd_en_d  = 1'b1;
            rd_bit_d = bit_q + 4'd1;
          end
        end else begin
          sclk_d = ((cnt_q + CNT_W'(1)) >= HALF);
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = LATCH;
          latch_d = 1'b1;
          rs_d    = ~(16'd1 << row_q);
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
        oe_n_d  = 1'b0;
      end
      DISPLAY: begin
        if (cnt_q == DISPLAY_LAST) begin
          if (!bus.enable) begin
            state_d = IDLE;
            row_d   = '0;
            oe_n_d  = 1'b1;
            rs_d    = '1;
          end else begin
            start_row = 1'b1;
            if (row_q == LAST_ROW) begin
              row_d         = '0;
              frame_start_d = 1'b1;
              if (bus.swap_request) begin
                fsel_d     = ~fsel_q;
                swap_ack_d = 1'b1;
              end
            end else begin
              row_d = row_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The previous row stays lit while the next one shifts, so oe_n/rs are left untouched here.
    if (start_row) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      bit_d    = '0;
      rd_en_d  = 1'b1;
      rd_bit_d = '0;
      sclk_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      row_q         <= '0;
      fsel_q        <= 1'b0;
      swap_ack_q    <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_bit_q      <= '0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      rs_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      row_q         <= row_d;
      fsel_q        <= fsel_d;
      swap_ack_q    <= swap_ack_d;
      rd_en_q       <= rd_en_d;
      rd_bit_q      <= rd_bit_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      rs_q          <= rs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.swap_ack         = swap_ack_q;
  assign bus.front_buffer_sel = fsel_q;
  assign bus.rd_en            = rd_en_q;
  assign bus.rd_row_addr      = row_q;
  assign bus.rd_bit_addr      = rd_bit_q;
  assign bus.serial_clk       = sclk_q;
  assign bus.latch_enable     = latch_q;
  assign bus.output_enable_n  = oe_n_q;
  assign bus.row_select_n     = rs_q;
  assign bus.frame_start      = frame_start_q;

endmodule
